// File: rtl/axi_reg_slice_defs.sv
// rtl/axi_reg_slice_defs.sv - shared definitions for the AXI register/FIFO slices
//
// Purpose: AX payload width helper, AX field offsets used for packing and
// unpacking, and the handshake-mode constants shared by the slice family.
// Ports: none (package).
package axi_reg_slice_defs;

  // Handshake modes of the register-slice family.
  typedef enum logic [1:0] {
    HS_BYPASS = 2'd0,
    HS_FWD    = 2'd1,
    HS_REV    = 2'd2,
    HS_FULL   = 2'd3
  } hs_mode_e;

  // Fixed-width AX fields: len 8, size 3, burst 2, lock 1, cache 4,
  // prot 3, region 4, qos 4.
  localparam int AX_FIXED_BITS = 29;

  // Field offsets measured from the top of the user field (user sits at
  // bit 0). The id offset is additionally shifted by ADDR_WIDTH.
  localparam int AX_QOS_OFS    = 0;
  localparam int AX_REGION_OFS = 4;
  localparam int AX_PROT_OFS   = 8;
  localparam int AX_CACHE_OFS  = 11;
  localparam int AX_LOCK_OFS   = 15;
  localparam int AX_BURST_OFS  = 16;
  localparam int AX_SIZE_OFS   = 18;
  localparam int AX_LEN_OFS    = 21;
  localparam int AX_ADDR_OFS   = 29;
  localparam int AX_ID_OFS     = 29;

  function automatic int ax_payld_width(input int id_w, input int addr_w, input int user_w);
    return AX_FIXED_BITS + id_w + addr_w + user_w;
  endfunction

endpackage

// File: rtl/axi_channel_fifo.sv
// rtl/axi_channel_fifo.sv - generic valid/ready channel FIFO with hold gating
//
// Purpose: DEPTH-entry FIFO for any AXI channel payload. Registered slave
// ready, occupancy counter, almost-full flag and a hold input that only
// blocks entries not yet presented on the master side.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   s_valid_i/s_ready_o   slave-side handshake, s_ready_o is a flop
//   s_data_i              slave-side payload
//   m_valid_o/m_ready_i   master-side handshake
//   m_data_o              master-side payload (head entry)
//   hold_i                blocks launch of a new head entry
//   level_o               occupancy, afull_o = level_o >= AFULL_THRESH
module axi_channel_fifo #(
  parameter int PAYLD_WIDTH  = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [PAYLD_WIDTH-1:0]       s_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [PAYLD_WIDTH-1:0]       m_data_o,
  input  logic                         hold_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         afull_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PAYLD_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ready_q, ready_d;
  logic                   launched_q, launched_d;
  logic                   push, pop, m_valid;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Once shown, the head stays shown until taken, whatever hold does.
  assign m_valid = (level_q != '0) && (launched_q || !hold_i);
  assign push    = s_valid_i && ready_q;
  assign pop     = m_valid && m_ready_i;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    launched_d = launched_q;
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    if (pop)
      launched_d = 1'b0;
    else if (m_valid && !m_ready_i)
      launched_d = 1'b1;
    // Ready looks at the next level so it never depends on m_ready_i
    // combinationally, only through the level register.
    ready_d = (level_d < LVL_W'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      launched_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      launched_q <= launched_d;
    end
  end

  // Storage needs no reset: contents are only visible while level_q != 0.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= s_data_i;
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = m_valid;
  assign m_data_o  = mem_q[rptr_q];
  assign level_o   = level_q;
  assign afull_o   = (level_q >= LVL_W'(AFULL_THRESH));

endmodule

// File: rtl/axi4_ax_fifo_slice.sv
// rtl/axi4_ax_fifo_slice.sv - AXI4 AW/AR channel FIFO slice
//
// Purpose: packs the AXI4 address-channel fields into one payload, buffers
// it in axi_channel_fifo and unpacks it on the master side, bit-exact.
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   axvalids/axreadys, ax*s slave-side handshake and AX fields
//   axvalidm/axreadym, ax*m master-side handshake and AX fields
//   hold                    blocks launch of new requests
//   level, axafull          occupancy and almost-full flag
module axi4_ax_fifo_slice
  import axi_reg_slice_defs::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int USER_WIDTH   = 1,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       axvalids,
  output logic                       axreadys,
  input  logic [ID_WIDTH-1:0]        axids,
  input  logic [ADDR_WIDTH-1:0]      axaddrs,
  input  logic [7:0]                 axlens,
  input  logic [2:0]                 axsizes,
  input  logic [1:0]                 axbursts,
  input  logic                       axlocks,
  input  logic [3:0]                 axcaches,
  input  logic [2:0]                 axprots,
  input  logic [3:0]                 axregions,
  input  logic [3:0]                 axqoss,
  input  logic [USER_WIDTH-1:0]      axusers,
  output logic                       axvalidm,
  input  logic                       axreadym,
  output logic [ID_WIDTH-1:0]        axidm,
  output logic [ADDR_WIDTH-1:0]      axaddrm,
  output logic [7:0]                 axlenm,
  output logic [2:0]                 axsizem,
  output logic [1:0]                 axburstm,
  output logic                       axlockm,
  output logic [3:0]                 axcachem,
  output logic [2:0]                 axprotm,
  output logic [3:0]                 axregionm,
  output logic [3:0]                 axqosm,
  output logic [USER_WIDTH-1:0]      axuserm,
  input  logic                       hold,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       axafull
);

  localparam int PW = ax_payld_width(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
  localparam int UB = USER_WIDTH;

  logic [PW-1:0] payld_s;
  logic [PW-1:0] payld_m;

  assign payld_s = {axids, axaddrs, axlens, axsizes, axbursts, axlocks,
                    axcaches, axprots, axregions, axqoss, axusers};

  axi_channel_fifo #(
    .PAYLD_WIDTH (PW),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(AFULL_THRESH)
  ) u_fifo (
    .clk_i    (aclk),
    .rst_i    (areset),
    .s_valid_i(axvalids),
    .s_ready_o(axreadys),
    .s_data_i (payld_s),
    .m_valid_o(axvalidm),
    .m_ready_i(axreadym),
    .m_data_o (payld_m),
    .hold_i   (hold),
    .level_o  (level),
    .afull_o  (axafull)
  );

  assign axuserm   = payld_m[0 +: USER_WIDTH];
  assign axqosm    = payld_m[UB + AX_QOS_OFS    +: 4];
  assign axregionm = payld_m[UB + AX_REGION_OFS +: 4];
  assign axprotm   = payld_m[UB + AX_PROT_OFS   +: 3];
  assign axcachem  = payld_m[UB + AX_CACHE_OFS  +: 4];
  assign axlockm   = payld_m[UB + AX_LOCK_OFS];
  assign axburstm  = payld_m[UB + AX_BURST_OFS  +: 2];
  assign axsizem   = payld_m[UB + AX_SIZE_OFS   +: 3];
  assign axlenm    = payld_m[UB + AX_LEN_OFS    +: 8];
  assign axaddrm   = payld_m[UB + AX_ADDR_OFS   +: ADDR_WIDTH];
  assign axidm     = payld_m[UB + AX_ID_OFS + ADDR_WIDTH +: ID_WIDTH];

endmodule

// File: tb/tb_axi4_ax_fifo_slice.sv
// tb/tb_axi4_ax_fifo_slice.sv - scoreboard bench for axi4_ax_fifo_slice (DEPTH 4 and 3)
module tb_axi4_ax_fifo_slice;

  localparam int PW = 66;  // id4 addr32 len8 size3 burst2 lock1 cache4 prot3 region4 qos4 user1

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic sel = 1'b0;  // 0: DEPTH=4 instance, 1: DEPTH=3 instance
  logic valids = 1'b0, readym = 1'b0, hold = 1'b0;
  logic [PW-1:0] spay = '0;

  logic valids_a, readym_a, readys_a, validm_a, afull_a;
  logic valids_b, readym_b, readys_b, validm_b, afull_b;
  logic [2:0] level_a;
  logic [1:0] level_b;
  logic [PW-1:0] mpay_a, mpay_b;

  logic cur_readys, cur_validm, cur_afull;
  logic [2:0] cur_level;
  logic [PW-1:0] cur_mpay;
  int cur_depth, cur_thresh;

  assign valids_a   = valids && !sel;
  assign readym_a   = readym && !sel;
  assign valids_b   = valids && sel;
  assign readym_b   = readym && sel;
  assign cur_readys = sel ? readys_b : readys_a;
  assign cur_validm = sel ? validm_b : validm_a;
  assign cur_afull  = sel ? afull_b : afull_a;
  assign cur_level  = sel ? {1'b0, level_b} : level_a;
  assign cur_mpay   = sel ? mpay_b : mpay_a;
  assign cur_depth  = sel ? 3 : 4;
  assign cur_thresh = sel ? 2 : 3;

  always #5 aclk = ~aclk;

  axi4_ax_fifo_slice #(.DEPTH(4), .AFULL_THRESH(3)) dut_a (
    .aclk(aclk), .areset(areset),
    .axvalids(valids_a), .axreadys(readys_a),
    .axids(spay[65:62]), .axaddrs(spay[61:30]), .axlens(spay[29:22]), .axsizes(spay[21:19]),
    .axbursts(spay[18:17]), .axlocks(spay[16]), .axcaches(spay[15:12]), .axprots(spay[11:9]),
    .axregions(spay[8:5]), .axqoss(spay[4:1]), .axusers(spay[0:0]),
    .axvalidm(validm_a), .axreadym(readym_a),
    .axidm(mpay_a[65:62]), .axaddrm(mpay_a[61:30]), .axlenm(mpay_a[29:22]), .axsizem(mpay_a[21:19]),
    .axburstm(mpay_a[18:17]), .axlockm(mpay_a[16]), .axcachem(mpay_a[15:12]), .axprotm(mpay_a[11:9]),
    .axregionm(mpay_a[8:5]), .axqosm(mpay_a[4:1]), .axuserm(mpay_a[0:0]),
    .hold(hold), .level(level_a), .axafull(afull_a)
  );

  axi4_ax_fifo_slice #(.DEPTH(3), .AFULL_THRESH(2)) dut_b (
    .aclk(aclk), .areset(areset),
    .axvalids(valids_b), .axreadys(readys_b),
    .axids(spay[65:62]), .axaddrs(spay[61:30]), .axlens(spay[29:22]), .axsizes(spay[21:19]),
    .axbursts(spay[18:17]), .axlocks(spay[16]), .axcaches(spay[15:12]), .axprots(spay[11:9]),
    .axregions(spay[8:5]), .axqoss(spay[4:1]), .axusers(spay[0:0]),
    .axvalidm(validm_b), .axreadym(readym_b),
    .axidm(mpay_b[65:62]), .axaddrm(mpay_b[61:30]), .axlenm(mpay_b[29:22]), .axsizem(mpay_b[21:19]),
    .axburstm(mpay_b[18:17]), .axlockm(mpay_b[16]), .axcachem(mpay_b[15:12]), .axprotm(mpay_b[11:9]),
    .axregionm(mpay_b[8:5]), .axqosm(mpay_b[4:1]), .axuserm(mpay_b[0:0]),
    .hold(hold), .level(level_b), .axafull(afull_b)
  );

  int errors = 0;
  int checks = 0;
  int cycle = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of accepted requests plus a flag
  // saying the head has been shown on the master side.
  logic [PW-1:0] mq[$];
  bit shown = 0;
  bit after_rst = 0;

  always @(negedge aclk) begin
    bit ev, push, pop;
    cycle++;
    if (areset) begin
      check("rst_level", cur_level, 0);
      check("rst_validm", cur_validm, 0);
      check("rst_readys", cur_readys, 0);
      check("rst_afull", cur_afull, 0);
      mq.delete();
      shown = 0;
      after_rst = 1;
    end else begin
      ev = (mq.size() != 0) && (shown || !hold);
      check("validm", cur_validm, ev);
      check("level", cur_level, mq.size());
      check("afull", cur_afull, mq.size() >= cur_thresh);
      if (after_rst) check("readys_first_cycle", cur_readys, 0);
      else           check("readys", cur_readys, mq.size() < cur_depth);
      after_rst = 0;
      if (ev) check("payload", cur_mpay, mq[0]);
      push = valids && cur_readys;
      pop  = cur_validm && readym;
      if (pop && mq.size() != 0) begin
        void'(mq.pop_front());
        shown = 0;
      end else if (ev && !readym) begin
        shown = 1;
      end
      if (push) mq.push_back(spay);
    end
  end

  function automatic logic [PW-1:0] rnd();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] mk(input logic [31:0] addr);
    logic [PW-1:0] p;
    p = rnd();
    p[61:30] = addr;
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Presents one request and returns just after the accepting edge; valid
  // is left high so back-to-back calls stream.
  task automatic send(input logic [PW-1:0] p);
    int n;
    n = 0;
    spay = p;
    valids = 1'b1;
    @(negedge aclk);
    while (!cur_readys && n < 50) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 50) check("send_timeout", cur_readys, 1);
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    valids = 1'b0;
    hold = 1'b0;
    readym = 1'b1;
    while (cur_level != 0 && n < 100) begin
      n++;
      tick(1);
    end
    check("drain_level", cur_level, 0);
    readym = 1'b0;
  endtask

  task automatic full_simul();
    for (int i = 0; i < cur_depth; i++) send(mk(32'h2000 + 32'(i) * 32'h40));
    valids = 1'b0;
    tick(1);
    check("full_level", cur_level, cur_depth);
    check("full_readys", cur_readys, 0);
    readym = 1'b1;
    send(mk(32'h3000));
    readym = 1'b0;
    valids = 1'b0;
    #1;
    check("full_simul_level", cur_level, cur_depth - 1);
    drain();
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      bit hs;
      @(negedge aclk);
      hs = valids && cur_readys;
      @(posedge aclk);
      #1;
      if (!valids || hs) begin
        valids = ($urandom % 4) != 0;
        spay = rnd();
      end
      readym = ($urandom % 3) != 0;
      hold = ($urandom % 5) == 0;
    end
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    logic [PW-1:0] p;

    // Reset and fill
    tick(2);
    check("init_readys", cur_readys, 0);
    check("init_validm", cur_validm, 0);
    areset = 1'b0;
    tick(1);
    check("readys_after_release", cur_readys, 1);
    for (int i = 0; i < 4; i++) send(mk(32'h1000 + 32'(i) * 32'h40));
    spay = mk(32'h1100);
    tick(4);
    check("fill_level", cur_level, 4);
    check("fill_readys", cur_readys, 0);
    check("fill_afull", cur_afull, 1);
    drain();

    // Streaming
    readym = 1'b1;
    c0 = cycle;
    for (int i = 0; i < 20; i++) begin
      p = mk(32'h4000 + 32'(i) * 32'h40);
      p[65:62] = 4'hA;
      p[29:22] = 8'd7;
      p[4:1]   = 4'd3;
      p[8:5]   = 4'd2;
      send(p);
    end
    check("stream_cycles", cycle - c0, 20);
    check("stream_level", cur_level, 1);
    drain();

    // Hold before launch
    hold = 1'b1;
    send(mk(32'h5000));
    send(mk(32'h5040));
    valids = 1'b0;
    tick(3);
    check("holdpre_validm", cur_validm, 0);
    check("holdpre_level", cur_level, 2);
    hold = 1'b0;
    readym = 1'b1;
    #1;
    check("holdpre_release", cur_validm, 1);
    drain();

    // Hold after launch
    send(mk(32'h6000));
    send(mk(32'h6040));
    valids = 1'b0;
    hold = 1'b1;
    tick(3);
    check("holdpost_validm", cur_validm, 1);
    readym = 1'b1;
    tick(1);
    readym = 1'b0;
    #1;
    check("holdpost_next_blocked", cur_validm, 0);
    tick(2);
    check("holdpost_level", cur_level, 1);
    drain();

    full_simul();
    random_phase(300);

    // Async reset mid-burst
    for (int i = 0; i < 3; i++) send(mk(32'h7000 + 32'(i) * 32'h40));
    valids = 1'b0;
    tick(1);
    check("prerst_validm", cur_validm, 1);
    @(posedge aclk);
    #3;
    areset = 1'b1;
    #1;
    check("async_validm", cur_validm, 0);
    check("async_readys", cur_readys, 0);
    check("async_level", cur_level, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    tick(3);
    check("postrst_validm", cur_validm, 0);
    send(mk(32'h7800));
    drain();

    // DEPTH=3 instance
    areset = 1'b1;
    sel = 1'b1;
    tick(1);
    areset = 1'b0;
    tick(2);
    full_simul();
    full_simul();
    random_phase(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_ax_fifo_slice.md
Name: axi4_ax_fifo_slice

Overview:
Parametrised AXI4 address-channel (AW or AR) buffer, DEPTH entries deep. It registers the full AXI4 AX payload between a slave-side and a master-side interface. It adds three things: an occupancy output, an almost-full flag, and a hold input that gates the launch of new requests without breaking AXI valid stability. It sits at interconnect or bridge boundaries where address requests must be absorbed, counted or throttled. It replaces a single-stage register slice where more elasticity is required.

Parameters:
ADDR_WIDTH, 32, address width
ID_WIDTH, 4, AxID width
USER_WIDTH, 1, AxUSER width
DEPTH, 4, number of entries; legal range is 1 to 64; values of 2 or more give full throughput
AFULL_THRESH, 3, axafull asserts when level >= AFULL_THRESH; legal range is 1 to DEPTH

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
axvalids  in  1  slave-side valid
axreadys  out  1  slave-side ready, driven from a flop
axids/axaddrs/axlens/axsizes/axbursts/axlocks/axcaches/axprots/axregions/axqoss/axusers  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  slave-side AX payload
axvalidm  out  1  master-side valid
axreadym  in  1  master-side ready
axidm/axaddrm/axlenm/axsizem/axburstm/axlockm/axcachem/axprotm/axregionm/axqosm/axuserm  out  same widths as slave side  master-side AX payload
hold  in  1  when high, no new request is launched on the master side
level  out  $clog2(DEPTH+1)  current occupancy
axafull  out  1  almost-full flag

Interface decisions:
- Single clock, aclk. Reset is areset: asynchronous assert, active-high. No aresetn.

Behaviour:
- Payload packing: PAYLD_WIDTH = ID_WIDTH+ADDR_WIDTH+USER_WIDTH+29. Packing order, MSB to LSB: id, addr, len, size, burst, lock, cache, prot, region, qos, user. The payload is carried bit-exact; no field is modified.
- Reset values: level=0, axreadys=0, axvalidm=0, axafull=0, launched=0. Read and write pointers are 0. Payload outputs are don't-care while axvalidm=0.
- Ready after reset: axreadys rises on the first aclk edge after areset deasserts.
- Push: occurs when axvalids and axreadys are both high. The entry is written at wptr; wptr increments modulo DEPTH.
- Pop: occurs when axvalidm and axreadym are both high. rptr increments modulo DEPTH.
- Level update: level_next = level + push - pop. Simultaneous push and pop leaves level unchanged.
- axreadys is registered: axreadys_q <= (level_next < DEPTH). There is no combinational path from axreadym to axreadys.
- Latency: a push in cycle N makes axvalidm high in cycle N+1 at the earliest, when the FIFO was empty and hold=0. There is no combinational pass-through from slave side to master side.
- Throughput: with DEPTH of 2 or more, one transfer per cycle is sustained. With DEPTH=1 the maximum rate is one transfer every 2 cycles. Entry order is preserved.
- axvalidm = (level != 0) && (launched || !hold).
- launched flag: set when axvalidm=1 and axreadym=0; cleared on pop.
- Hold rule 1: once axvalidm is asserted it stays high, with stable payload, until the handshake completes, regardless of hold. This preserves AXI valid stability.
- Hold rule 2: a hold that rises in the same cycle as a pop blocks the next entry. The next entry has not been launched, so it is not shown.
- hold has no effect on axreadys. Push continues while held until the FIFO is full.
- axafull = (level >= AFULL_THRESH). It is combinational from the level register.
- Full: level=DEPTH forces axreadys=0 from the next edge onward. A pop in the full cycle re-raises axreadys on the following edge.
- Empty: level=0 forces axvalidm=0. Payload outputs hold the last head value (don't-care).
- Pointer wrap: both pointers wrap at DEPTH-1 → 0. The design must work for non-power-of-2 DEPTH.
- Reset mid-operation: all contents are discarded; outputs return to their reset values asynchronously. Upstream and downstream blocks must be reset in the same domain.

Decomposition:
- Shared package/header axi_reg_slice_defs holds:
  - the AX payload-width macro/function (29 + ID + ADDR + USER);
  - the field offsets for packing;
  - the existing handshake-mode constants.
- Sub-module axi_channel_fifo (generic PAYLD_WIDTH, DEPTH, AFULL_THRESH) contains:
  - storage array and pointers;
  - level counter and registered ready;
  - launched/hold logic and afull.
- axi4_ax_fifo_slice only packs and unpacks fields around axi_channel_fifo. The same FIFO is reusable for the W, R and B channels.

Test Plan:
- Reset and fill: hold reset, release, axreadym=0, push 4 requests (addr 0x1000, 0x1040, 0x1080, 0x10C0) at DEPTH=4 → axreadys=1 on the first edge after release; level reaches 4; axafull high from level 3; axreadys=0 after the 4th push; no 5th push is accepted.
- Streaming: axreadym=1, axvalids=1 for 20 cycles, addr increments by 0x40 → axvalidm rises 1 cycle after the first push; one pop per cycle; level stays at 1; order and all fields (id=0xA, len=7, qos=3, region=2) match bit-exact.
- Hold before launch: hold=1 with 2 entries queued and axvalidm=0 → axvalidm stays 0 and level=2; drop hold → axvalidm=1 the same cycle; entries drain in order.
- Hold after launch: axvalidm=1, axreadym=0, then raise hold → axvalidm stays 1 with stable payload until axreadym=1; the next entry is not presented while hold=1.
- Full with simultaneous push/pop: level=4, pop in cycle N → axreadys=1 in cycle N+1; push and pop in cycle N+1 keep level=3 and preserve order. Repeat with DEPTH=3 to exercise wrap with non-power-of-2 depth.
- Async reset mid-burst: assert areset between edges with level=3 and axvalidm=1 → axvalidm, axreadys and level go to 0 immediately; after release no stale entry appears.
